// File: rtl/ecg_bank_mem.sv
// ECG accelerator multi-bank data memory with stream loader and clear sequencer.
// Memory arrays carry no reset so each bank maps onto a block RAM.
module ecg_bank_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned NUM_BANKS  = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned BW = $clog2(NUM_BANKS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  csen_i,
   input  logic                  clr_start_i,
   input  logic                  ld_start_i,
   input  logic                  ld_valid_i,
   input  logic [DATA_WIDTH-1:0] ld_data_i,
   output logic                  ld_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  rd_en_i,
   input  logic [BW-1:0]         rd_bank_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   input  logic                  wr_en_i,
   input  logic [BW-1:0]         wr_bank_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  acc_err_o
);

   localparam int unsigned CW = BW + AW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD
   } state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    acc_err_q, acc_err_d;
   logic                    rd_valid_q, rd_valid_d;
   logic [BW-1:0]           rd_bank_q;
   logic                    acc_ok;
   logic                    we;
   logic [BW-1:0]           wbank;
   logic [AW-1:0]           waddr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH-1:0]   bank_rd [NUM_BANKS];

   assign acc_ok = (state_q == S_IDLE) && csen_i;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      we         = 1'b0;
      wbank      = wr_bank_i;
      waddr      = wr_addr_i;
      wdata      = wr_data_i;
      rd_valid_d = acc_ok && rd_en_i;
      acc_err_d  = (state_q != S_IDLE) && csen_i && (rd_en_i || wr_en_i);
      unique case (state_q)
         S_IDLE: begin
            we = acc_ok && wr_en_i;
            if (clr_start_i) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end else if (ld_start_i) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            we    = 1'b1;
            wbank = cnt_q[CW-1:AW];
            waddr = cnt_q[AW-1:0];
            wdata = '0;
            cnt_d = cnt_q + CW'(1);
            if (&cnt_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_LOAD: begin
            wbank = cnt_q[CW-1:AW];
            waddr = cnt_q[AW-1:0];
            wdata = ld_data_i;
            if (ld_valid_i) begin
               we    = 1'b1;
               cnt_d = cnt_q + CW'(1);
               if (&cnt_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         acc_err_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_bank_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         acc_err_q  <= acc_err_d;
         rd_valid_q <= rd_valid_d;
         if (rd_valid_d) rd_bank_q <= rd_bank_i;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem_q [DEPTH];
      logic [DATA_WIDTH-1:0] rd_q;

      // Read-before-write: a same-address read sees the old word.
      always_ff @(posedge clk) begin
         if (we && (wbank == BW'(b))) mem_q[waddr] <= wdata;
         if (rd_valid_d && (rd_bank_i == BW'(b))) rd_q <= mem_q[rd_addr_i];
      end

      assign bank_rd[b] = rd_q;
   end

   assign rd_data_o  = rd_valid_q ? bank_rd[rd_bank_q] : '0;
   assign rd_valid_o = rd_valid_q;
   assign ld_ready_o = (state_q == S_LOAD);
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign acc_err_o  = acc_err_q;

endmodule

// File: tb/tb_ecg_bank_mem.sv
// Directed bench for ecg_bank_mem: clear, stream load, accelerator port,
// busy-time error reporting, mid-load reset and start-pulse priority.
module tb_ecg_bank_mem;

   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int NB = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          csen, clr_start, ld_start, ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready, busy, done;
   logic          rd_en;
   logic [0:0]    rd_bank;
   logic [3:0]    rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          wr_en;
   logic [0:0]    wr_bank;
   logic [3:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic          acc_err;

   int checks = 0;
   int failures = 0;
   int done_seen = 0;
   int ld_idx = 0;
   logic [7:0] ld_base = 8'h00;

   ecg_bank_mem #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .NUM_BANKS (NB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .csen_i     (csen),
      .clr_start_i(clr_start),
      .ld_start_i (ld_start),
      .ld_valid_i (ld_valid),
      .ld_data_i  (ld_data),
      .ld_ready_o (ld_ready),
      .busy_o     (busy),
      .done_o     (done),
      .rd_en_i    (rd_en),
      .rd_bank_i  (rd_bank),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .wr_en_i    (wr_en),
      .wr_bank_i  (wr_bank),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .acc_err_o  (acc_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
   endtask

   task automatic rd(input logic b, input logic [3:0] a,
                     input logic [7:0] exp, input string tag);
      rd_en   = 1'b1;
      rd_bank = b;
      rd_addr = a;
      step();
      rd_en = 1'b0;
      chk({tag, "_valid"}, rd_valid, 1);
      chk(tag, rd_data, exp);
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = ld_base + ld_idx[7:0];
         step();
         ld_idx++;
      end
      ld_valid = 1'b0;
   endtask

   initial begin
      int busy_n;
      int rdy_n;
      int k;
      int kdone;
      logic v;
      logic rdy;

      rst_n = 1'b0;
      csen = 1'b1;
      clr_start = 1'b0;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_data = '0;
      rd_en = 1'b0;
      rd_bank = '0;
      rd_addr = '0;
      wr_en = 1'b0;
      wr_bank = '0;
      wr_addr = '0;
      wr_data = '0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_ready", ld_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_err", acc_err, 0);
      chk("rst_rdata", rd_data, 0);
      rst_n = 1'b1;
      step();

      // 1: clear
      done_seen = 0;
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_n++;
         step();
      end
      chk("clr_busy_cycles", busy_n, 32);
      chk("clr_done_pulses", done_seen, 1);
      for (int i = 0; i < 32; i++) rd(i[4], i[3:0], 8'h00, "clr_rd");
      step();
      chk("idle_rdv", rd_valid, 0);
      chk("idle_rdata", rd_data, 0);

      // 2: load with ld_valid toggling
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      chk("ld_ready", ld_ready, 1);
      done_seen = 0;
      k = 0;
      kdone = -1;
      for (int cyc = 0; cyc < 200 && kdone < 0; cyc++) begin
         v = (cyc % 2 == 0);
         ld_valid = v;
         ld_data = k[7:0];
         rdy = ld_ready;
         step();
         if (v && rdy) k++;
         if (done) kdone = k;
      end
      ld_valid = 1'b0;
      chk("ld_done_at", kdone, 32);
      chk("ld_done_pulses", done_seen, 1);
      chk("ld_busy_end", busy, 0);
      chk("ld_ready_end", ld_ready, 0);
      rd(1'b1, 4'd5, 8'h15, "ld_b1a5");
      rd(1'b0, 4'd15, 8'h0F, "ld_b0a15");
      rd(1'b1, 4'd15, 8'h1F, "ld_b1a15");

      // 3: same-cycle read/write
      wr_en = 1'b1;
      wr_bank = 1'b0;
      wr_addr = 4'd3;
      wr_data = 8'hA5;
      rd_en = 1'b1;
      rd_bank = 1'b0;
      rd_addr = 4'd3;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("rw_old", rd_data, 8'h03);
      rd(1'b0, 4'd3, 8'hA5, "rw_new");

      // 4: accelerator access during load
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      done_seen = 0;
      ld_base = 8'h40;
      ld_idx = 0;
      feed(5);
      rd_en = 1'b1;
      wr_en = 1'b1;
      wr_data = 8'h55;
      step();
      chk("busy_err1", acc_err, 1);
      chk("busy_rdv", rd_valid, 0);
      chk("busy_rdata", rd_data, 0);
      step();
      chk("busy_err2", acc_err, 1);
      csen = 1'b0;
      step();
      chk("nocs_err1", acc_err, 0);
      step();
      chk("nocs_err2", acc_err, 0);
      rd_en = 1'b0;
      wr_en = 1'b0;
      csen = 1'b1;
      feed(27);
      chk("ld2_done", done_seen, 1);
      chk("ld2_busy", busy, 0);
      rd(1'b0, 4'd3, 8'h43, "ld2_b0a3");
      rd(1'b1, 4'd15, 8'h5F, "ld2_b1a15");

      // 5: reset mid-load, then restart
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      done_seen = 0;
      ld_base = 8'h60;
      ld_idx = 0;
      feed(10);
      rst_n = 1'b0;
      #2;
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", ld_ready, 0);
      chk("mrst_done", done, 0);
      rst_n = 1'b1;
      step();
      step();
      chk("mrst_no_done", done_seen, 0);
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      ld_base = 8'h80;
      ld_idx = 0;
      feed(32);
      chk("rs_done", done_seen, 1);
      rd(1'b0, 4'd0, 8'h80, "rs_b0a0");
      rd(1'b0, 4'd9, 8'h89, "rs_b0a9");
      rd(1'b1, 4'd15, 8'h9F, "rs_b1a15");

      // 6: clr_start beats ld_start; ld_start ignored mid-clear
      done_seen = 0;
      clr_start = 1'b1;
      ld_start = 1'b1;
      step();
      clr_start = 1'b0;
      ld_start = 1'b0;
      chk("pri_ready", ld_ready, 0);
      chk("pri_busy", busy, 1);
      busy_n = 1;
      rdy_n = 0;
      for (int i = 0; i < 40; i++) begin
         ld_start = (i == 5);
         step();
         if (busy) busy_n++;
         if (ld_ready) rdy_n++;
      end
      ld_start = 1'b0;
      chk("pri_busy_cycles", busy_n, 32);
      chk("pri_done_pulses", done_seen, 1);
      chk("pri_ready_cycles", rdy_n, 0);
      rd(1'b1, 4'd15, 8'h00, "pri_b1a15");
      rd(1'b0, 4'd9, 8'h00, "pri_b0a9");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
